// File: rtl/ats_eligibility_arbiter.sv
// Round-robin front end sharing one ATS eligibility calculator among NUM_PORT requesters.
// Each grant runs start -> wait for result/timeout -> response handshake -> read_end -> quiet gap.
module ats_eligibility_arbiter #(
    parameter int unsigned NUM_PORT        = 4,
    parameter int unsigned TIMESTAMP_WIDTH = 59,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORT-1:0]             req_valid,
    output logic [NUM_PORT-1:0]             req_ready,
    input  logic [NUM_PORT*32-1:0]          req_flow_id,
    input  logic [NUM_PORT*5-1:0]           req_group_id,
    input  logic [NUM_PORT*TIMESTAMP_WIDTH-1:0] req_arrival_time,
    input  logic [NUM_PORT*16-1:0]          req_frame_length,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NUM_PORT-1:0]             rsp_port,
    output logic [TIMESTAMP_WIDTH-1:0]      rsp_eligible_time,
    output logic                            rsp_discard,
    output logic                            rsp_timeout,
    output logic                            calc_start_flag,
    output logic [31:0]                     calc_flow_id,
    output logic [4:0]                      calc_group_id,
    output logic [TIMESTAMP_WIDTH-1:0]      calc_arrival_time,
    output logic [15:0]                     calc_frame_length,
    output logic                            calc_read_end_flag,
    input  logic [TIMESTAMP_WIDTH-1:0]      calc_eligible_time,
    input  logic                            calc_eligible_time_OK,
    input  logic                            calc_discard_flag,
    output logic                            busy,
    output logic [15:0]                     served_count,
    output logic [15:0]                     timeout_count
);

    localparam int unsigned PortW  = $clog2(NUM_PORT);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW   = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StGap} state_e;

    state_e              state_q, state_d;
    logic [PortW-1:0]    last_grant_q;
    logic [PortW-1:0]    grant_idx;
    logic                any_valid;
    logic [TimerW-1:0]   timer_q;
    logic [GapW-1:0]     gap_q;
    logic                timer_expired;
    logic                gap_done;

    // Search starts one past the last grant so every port gets a turn.
    always_comb begin : arbiter
        int p;
        logic [PortW-1:0] p_idx;
        p         = 0;
        p_idx     = '0;
        grant_idx = last_grant_q;
        any_valid = 1'b0;
        for (int i = 1; i <= int'(NUM_PORT); i++) begin
            p = int'(last_grant_q) + i;
            if (p >= int'(NUM_PORT)) p = p - int'(NUM_PORT);
            p_idx = PortW'(p);
            if (!any_valid && req_valid[p_idx]) begin
                any_valid = 1'b1;
                grant_idx = p_idx;
            end
        end
    end

    assign timer_expired = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
    assign gap_done      = (gap_q == GapW'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (calc_eligible_time_OK || timer_expired) state_d = StDone;
            StDone:  if (rsp_ready) state_d = StGap;
            StGap:   if (gap_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && any_valid && !reset) begin
            req_ready = NUM_PORT'(1) << grant_idx;
        end
        calc_start_flag    = (state_q == StIssue);
        calc_read_end_flag = (state_q == StGap) && (gap_q == '0);
        rsp_valid          = (state_q == StDone);
        busy               = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            last_grant_q      <= PortW'(NUM_PORT - 1);
            timer_q           <= '0;
            gap_q             <= '0;
            calc_flow_id      <= '0;
            calc_group_id     <= '0;
            calc_arrival_time <= '0;
            calc_frame_length <= '0;
            rsp_port          <= '0;
            rsp_eligible_time <= '0;
            rsp_discard       <= 1'b0;
            rsp_timeout       <= 1'b0;
            served_count      <= '0;
            timeout_count     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        last_grant_q      <= grant_idx;
                        calc_flow_id      <= req_flow_id[int'(grant_idx)*32 +: 32];
                        calc_group_id     <= req_group_id[int'(grant_idx)*5 +: 5];
                        calc_arrival_time <=
                            req_arrival_time[int'(grant_idx)*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH];
                        calc_frame_length <= req_frame_length[int'(grant_idx)*16 +: 16];
                    end
                end
                StIssue: timer_q <= '0;
                StWait: begin
                    // A result landing on the timeout cycle still counts as a normal response.
                    if (calc_eligible_time_OK) begin
                        rsp_port          <= NUM_PORT'(1) << last_grant_q;
                        rsp_eligible_time <= calc_eligible_time;
                        rsp_discard       <= calc_discard_flag;
                        rsp_timeout       <= 1'b0;
                    end else if (timer_expired) begin
                        rsp_port          <= NUM_PORT'(1) << last_grant_q;
                        rsp_eligible_time <= '0;
                        rsp_discard       <= 1'b1;
                        rsp_timeout       <= 1'b1;
                        if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        served_count <= served_count + 16'd1;
                        gap_q        <= '0;
                    end
                end
                StGap: gap_q <= gap_q + GapW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ats_eligibility_arbiter.sv
// Directed bench for ats_eligibility_arbiter: table of single transactions plus
// hand-written round-robin, stale-strobe and mid-operation reset sequences.
module tb_ats_eligibility_arbiter;

    localparam int TSW = 59;
    localparam int NP  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_ready;
    logic [NP*32-1:0]  req_flow_id;
    logic [NP*5-1:0]   req_group_id;
    logic [NP*TSW-1:0] req_arrival_time;
    logic [NP*16-1:0]  req_frame_length;
    logic            rsp_valid, rsp_ready;
    logic [NP-1:0]   rsp_port;
    logic [TSW-1:0]  rsp_eligible_time;
    logic            rsp_discard, rsp_timeout;
    logic            calc_start_flag, calc_read_end_flag;
    logic [31:0]     calc_flow_id;
    logic [4:0]      calc_group_id;
    logic [TSW-1:0]  calc_arrival_time;
    logic [15:0]     calc_frame_length;
    logic [TSW-1:0]  calc_eligible_time;
    logic            calc_eligible_time_OK, calc_discard_flag;
    logic            busy;
    logic [15:0]     served_count, timeout_count;

    ats_eligibility_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_flow_id(req_flow_id), .req_group_id(req_group_id),
        .req_arrival_time(req_arrival_time), .req_frame_length(req_frame_length),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_eligible_time(rsp_eligible_time), .rsp_discard(rsp_discard),
        .rsp_timeout(rsp_timeout), .calc_start_flag(calc_start_flag),
        .calc_flow_id(calc_flow_id), .calc_group_id(calc_group_id),
        .calc_arrival_time(calc_arrival_time), .calc_frame_length(calc_frame_length),
        .calc_read_end_flag(calc_read_end_flag), .calc_eligible_time(calc_eligible_time),
        .calc_eligible_time_OK(calc_eligible_time_OK), .calc_discard_flag(calc_discard_flag),
        .busy(busy), .served_count(served_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [31:0] flow;
        logic [4:0]  group;
        logic [TSW-1:0] arrival;
        logic [15:0] len;
        int         ok_delay;
        bit         no_ok;
        logic [TSW-1:0] elig;
        bit         disc;
        int         stall;
        logic [3:0] exp_port;
        logic [TSW-1:0] exp_time;
        bit         exp_disc;
        bit         exp_to;
        int         exp_lat;
    } vec_t;

    vec_t vecs[4];
    int checks = 0;
    int failures = 0;
    int exp_served = 0;
    int exp_timeouts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_flow_id = '0; req_group_id = '0;
        req_arrival_time = '0; req_frame_length = '0; rsp_ready = 1'b0;
        calc_eligible_time = '0; calc_eligible_time_OK = 1'b0; calc_discard_flag = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [31:0] flow, input logic [4:0] grp,
                           input logic [TSW-1:0] arr, input logic [15:0] len);
        req_valid[p] = 1'b1;
        req_flow_id[p*32 +: 32] = flow;
        req_group_id[p*5 +: 5] = grp;
        req_arrival_time[p*TSW +: TSW] = arr;
        req_frame_length[p*16 +: 16] = len;
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_ready"}, {60'd0, req_ready}, 64'd0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_port, rsp_discard, rsp_timeout}, 64'd0);
        chk({tag, "_rsp_time"}, {5'd0, rsp_eligible_time}, 64'd0);
        chk({tag, "_calc_flags"}, {calc_start_flag, calc_read_end_flag, busy}, 64'd0);
        chk({tag, "_calc_fields"}, {calc_flow_id, calc_group_id, calc_frame_length}, 64'd0);
        chk({tag, "_calc_arr"}, {5'd0, calc_arrival_time}, 64'd0);
        chk({tag, "_counters"}, {served_count, timeout_count}, 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        int lat;
        int wc;
        set_req(v.port, v.flow, v.group, v.arrival, v.len);
        #1;
        chk("txn_grant", {60'd0, req_ready}, {60'd0, v.exp_port});
        tick();
        req_valid = '0;
        chk("txn_start", {63'd0, calc_start_flag}, 64'd1);
        chk("txn_fields", {calc_flow_id, calc_group_id, calc_frame_length},
            {11'd0, v.flow, v.group, v.len});
        chk("txn_arrival", {5'd0, calc_arrival_time}, {5'd0, v.arrival});
        lat = 1;
        tick();
        chk("txn_start_once", {63'd0, calc_start_flag}, 64'd0);
        wc = 0;
        while (!rsp_valid && lat < 200) begin
            calc_eligible_time_OK = !v.no_ok && (wc == v.ok_delay);
            calc_eligible_time = v.elig;
            calc_discard_flag = v.disc;
            tick();
            calc_eligible_time_OK = 1'b0;
            lat++;
            wc++;
        end
        if (v.exp_to) exp_timeouts++;
        chk("txn_latency", 64'(lat), 64'(v.exp_lat));
        chk("txn_rsp", {rsp_valid, rsp_port, rsp_discard, rsp_timeout},
            {57'd0, 1'b1, v.exp_port, v.exp_disc, v.exp_to});
        chk("txn_rsp_time", {5'd0, rsp_eligible_time}, {5'd0, v.exp_time});
        chk("txn_timeout_count", {48'd0, timeout_count}, 64'(exp_timeouts));
        for (int s = 0; s < v.stall; s++) begin
            tick();
            chk("txn_stall_hold", {rsp_valid, calc_read_end_flag, rsp_eligible_time, rsp_discard},
                {2'b10, v.exp_time, v.exp_disc});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_served++;
        chk("txn_read_end", {calc_read_end_flag, rsp_valid}, 64'b10);
        chk("txn_served", {48'd0, served_count}, 64'(exp_served));
        chk("txn_hold_in_gap", {32'd0, calc_flow_id}, {32'd0, v.flow});
        tick();
        chk("txn_gap2", {calc_read_end_flag, busy}, 64'b01);
        tick();
        chk("txn_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        port flow          grp arrival               len  dly no  elig                     d stall port    exp_time                 d  to lat
        vecs[0] = '{1, 32'd7,        5'd3,  59'h100,             16'd100, 3,  0, 59'h1234,           0, 0,  4'b0010, 59'h1234,           0, 0, 5};
        vecs[1] = '{2, 32'hDEADBEEF, 5'd31, 59'h7FF_FFFF_FFFF_FFFF, 16'hFFFF, 0, 0, 59'h0AB_CDEF_0123_4567, 1, 10, 4'b0100, 59'h0AB_CDEF_0123_4567, 1, 0, 2};
        vecs[2] = '{3, 32'd99,       5'd1,  59'h42,              16'd64,  0,  1, 59'h777,            0, 0,  4'b1000, 59'h0,              1, 1, 65};
        vecs[3] = '{0, 32'd5,        5'd0,  59'h1,               16'd1500, 63, 0, 59'hABC,           0, 0,  4'b0001, 59'hABC,            0, 0, 65};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_zero_state("reset");
        reset = 1'b0;
        tick();
        chk("idle_no_req", {59'd0, req_ready, busy}, 64'd0);

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Round robin from a fresh reset: all ports continuously valid, instant results.
        begin
            int exp_seq[5] = '{0, 1, 2, 3, 0};
            int grants = 0;
            int last_t = 0;
            int t = 0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            exp_served = 0;
            exp_timeouts = 0;
            for (int p = 0; p < NP; p++) set_req(p, 32'(100 + p), 5'(p), 59'(p), 16'(p));
            calc_eligible_time_OK = 1'b1;
            calc_eligible_time = 59'h55;
            rsp_ready = 1'b1;
            #1;
            while (grants < 5 && t < 100) begin
                if (req_ready != '0) begin
                    chk("rr_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
                    chk("rr_port", {60'd0, req_ready}, 64'(1) << exp_seq[grants]);
                    if (grants > 0) chk("rr_spacing", 64'(t - last_t), 64'd6);
                    last_t = t;
                    grants++;
                end
                tick();
                t++;
            end
            chk("rr_grant_count", 64'(grants), 64'd5);
            req_valid = '0;
            t = 0;
            while (busy && t < 50) begin
                tick();
                t++;
            end
            chk("rr_drained", {63'd0, busy}, 64'd0);
            chk("rr_served", {48'd0, served_count}, 64'd5);
            clear_inputs();
        end

        // Stale OK during GAP/IDLE/ISSUE must be ignored; new request waits for the gap.
        set_req(2, 32'd22, 5'd2, 59'h22, 16'd22);
        #1;
        chk("stale_grant1", {60'd0, req_ready}, 64'b0100);
        tick();
        req_valid = '0;
        tick();
        calc_eligible_time_OK = 1'b1;
        calc_eligible_time = 59'h1111;
        tick();
        calc_eligible_time_OK = 1'b0;
        chk("stale_rsp1", {5'd0, rsp_eligible_time}, 64'h1111);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        calc_eligible_time_OK = 1'b1;
        calc_eligible_time = 59'hBAD;
        calc_discard_flag = 1'b1;
        set_req(1, 32'd55, 5'd5, 59'h55, 16'd55);
        #1;
        chk("stale_gap1", {59'd0, calc_read_end_flag, req_ready}, 64'b10000);
        tick();
        chk("stale_gap2", {59'd0, calc_read_end_flag, req_ready}, 64'd0);
        tick();
        chk("stale_grant2", {60'd0, req_ready}, 64'b0010);
        chk("stale_fields_held", {32'd0, calc_flow_id}, 64'd22);
        tick();
        req_valid = '0;
        chk("stale_issue", {calc_start_flag, calc_flow_id}, {31'd0, 1'b1, 32'd55});
        tick();
        calc_eligible_time_OK = 1'b0;
        tick();
        calc_eligible_time_OK = 1'b1;
        calc_eligible_time = 59'h5678;
        calc_discard_flag = 1'b0;
        tick();
        calc_eligible_time_OK = 1'b0;
        chk("stale_rsp2", {rsp_valid, rsp_port, rsp_discard, rsp_timeout}, 64'b1_0010_00);
        chk("stale_rsp2_time", {5'd0, rsp_eligible_time}, 64'h5678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("stale_done", {47'd0, busy, served_count}, 64'd7);

        // Reset while waiting on the calculator.
        set_req(3, 32'd33, 5'd3, 59'h33, 16'd33);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        req_valid = 4'b1111;
        tick();
        check_zero_state("midreset");
        reset = 1'b0;
        #1;
        chk("midreset_port0_first", {60'd0, req_ready}, 64'b0001);
        tick();
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
